// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory, packing 4 bytes per 32-bit word (big-endian).
// Latency: the 4th byte of a word is accepted in cycle N, its write strobe is in N+1, and done/cpu_reset release in N+2 after the last word.
// Backpressure: byte_ready is high only in COLLECT; bytes offered at any other time are left unconsumed.
//
// Ports: clock/reset (sync, active-high); start + word_count request a load;
//        byte_in/byte_valid/byte_ready byte stream; mem_* instruction-memory write port;
//        cpu_reset holds the CPU until a program is loaded; busy/done/err_length status.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          MAX_WORDS   = 256,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   mem_write_enabled,
  output logic [31:0]            mem_input_address,
  output logic [31:0]            mem_input_data,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   err_length
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  // One extra bit so MAX_WORDS itself is representable even when it equals 2^COUNT_WIDTH.
  localparam logic [COUNT_WIDTH:0] MAX_W = (COUNT_WIDTH+1)'(MAX_WORDS);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] index_q, index_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  // Only the first three bytes need storing; the fourth goes straight into the data register.
  logic [23:0]            word_q, word_d;

  logic        byte_ready_q, byte_ready_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic                   accept;
  logic                   start_ok;
  logic [COUNT_WIDTH-1:0] index_next;

  assign accept     = byte_valid & byte_ready_q;
  assign start_ok   = (word_count != '0) && ({1'b0, word_count} <= MAX_W);
  assign index_next = index_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    index_d      = index_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    byte_ready_d = byte_ready_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    cpu_reset_d  = cpu_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = 1'b0;

    case (state_q)
      // A rejected start in DONE leaves the loaded program running untouched.
      IDLE, DONE: begin
        if (start) begin
          if (start_ok) begin
            state_d      = COLLECT;
            count_d      = word_count;
            index_d      = '0;
            byte_cnt_d   = 2'd0;
            byte_ready_d = 1'b1;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            cpu_reset_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (accept) begin
          word_d = {word_q[15:0], byte_in};
          if (byte_cnt_q == 2'd3) begin
            state_d      = WRITE;
            byte_cnt_d   = 2'd0;
            byte_ready_d = 1'b0;
            we_d         = 1'b1;
            addr_d       = BASE_ADDR + (32'(index_q) << 2);
            data_d       = {word_q, byte_in};
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      WRITE: begin
        index_d = index_next;
        if (index_next == count_q) begin
          state_d      = DONE;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cpu_reset_d  = 1'b0;
        end else begin
          state_d      = COLLECT;
          byte_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      index_q      <= '0;
      byte_cnt_q   <= 2'd0;
      word_q       <= 24'd0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      data_q       <= 32'd0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      index_q      <= index_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready        = byte_ready_q;
  assign mem_write_enabled = we_q;
  assign mem_input_address = addr_q;
  assign mem_input_data    = data_q;
  assign cpu_reset         = cpu_reset_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err_length        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader; a second instance with BASE_ADDR=0x100 shares all inputs.
// Latency: checks are made 1 time unit after each rising edge, against hand-computed values.
// Backpressure: bytes are offered with byte_valid, optionally with random idle gaps.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready, wen, cpu_reset, busy, done, err_length;
  logic [31:0] addr, data;
  logic        byte_ready_b, wen_b, cpu_reset_b, busy_b, done_b, err_length_b;
  logic [31:0] addr_b, data_b;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int wr_mark;

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_write_enabled(wen), .mem_input_address(addr), .mem_input_data(data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err_length(err_length)
  );

  imem_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(256), .COUNT_WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_b),
    .mem_write_enabled(wen_b), .mem_input_address(addr_b), .mem_input_data(data_b),
    .cpu_reset(cpu_reset_b), .busy(busy_b), .done(done_b), .err_length(err_length_b)
  );

  // Counts every write strobe of the base-0 instance.
  always @(negedge clock) if (wen) wr_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [15:0] cnt);
    start = 1'b1;
    word_count = cnt;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_rdy", byte_ready, 1);
    chk("start_cpu_rst", cpu_reset, 1);
    chk("start_done", done, 0);
    chk("start_cpu_rst_b", cpu_reset_b, 1);
    chk("start_done_b", done_b, 0);
  endtask

  // Rejected start: err_length pulses for exactly one cycle and the block stays put.
  task automatic bad_start(input logic [15:0] cnt, input logic exp_done);
    start = 1'b1;
    word_count = cnt;
    tick;
    start = 1'b0;
    chk("bad_err", err_length, 1);
    chk("bad_busy", busy, 0);
    chk("bad_rdy", byte_ready, 0);
    chk("bad_cpu_rst", cpu_reset, {31'd0, ~exp_done});
    chk("bad_done", done, {31'd0, exp_done});
    tick;
    chk("bad_err_clr", err_length, 0);
    chk("bad_we", wen, 0);
  endtask

  // Sends one word big-endian and checks the write cycle and the cycle after it.
  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input bit gaps, input bit last);
    logic [31:0] ww;
    ww = w;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
          byte_valid = 1'b0;
          byte_in = 8'($urandom);
          tick;
          chk("gap_we", wen, 0);
        end
      end
      chk("byte_rdy", byte_ready, 1);
      byte_valid = 1'b1;
      byte_in = ww[31:24];
      ww = ww << 8;
      tick;
      if (i < 3) chk("we_early", wen, 0);
    end
    // Junk offered during WRITE must not be consumed.
    byte_valid = 1'b1;
    byte_in = 8'hEE;
    chk("wr_we", wen, 1);
    chk("wr_rdy", byte_ready, 0);
    chk("wr_addr", addr, a);
    chk("wr_data", data, w);
    chk("wr_addr_b", addr_b, a + 32'h100);
    chk("wr_data_b", data_b, w);
    tick;
    byte_valid = 1'b0;
    chk("post_we", wen, 0);
    if (last) begin
      chk("post_done", done, 1);
      chk("post_cpu_rst", cpu_reset, 0);
      chk("post_busy", busy, 0);
      chk("post_rdy", byte_ready, 0);
      chk("post_done_b", done_b, 1);
    end else begin
      chk("post_rdy", byte_ready, 1);
      chk("post_busy", busy, 1);
      chk("post_done", done, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    word_count = 16'd0;
    byte_in = 8'd0;
    byte_valid = 1'b0;
    tick;
    tick;
    chk("rst_rdy", byte_ready, 0);
    chk("rst_we", wen, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_addr_b", addr_b, 32'h100);
    chk("rst_data", data, 32'h0);
    chk("rst_cpu_rst", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_length, 0);
    reset = 1'b0;
    tick;

    // Bad length from IDLE.
    wr_mark = wr_total;
    bad_start(16'd0, 1'b0);
    bad_start(16'd257, 1'b0);
    chk("bad_nwr", wr_total - wr_mark, 0);

    // Normal two-word load, valid every cycle.
    wr_mark = wr_total;
    do_start(16'd2);
    send_word(32'h12345678, 32'h0, 1'b0, 1'b0);
    send_word(32'h9ABCDEF0, 32'h4, 1'b0, 1'b1);
    tick;
    tick;
    chk("norm_nwr", wr_total - wr_mark, 2);
    chk("norm_done_sticky", done, 1);
    chk("norm_addr_hold", addr, 32'h4);
    chk("norm_data_hold", data, 32'h9ABCDEF0);

    // Reload from DONE: second instance lands at its own base.
    wr_mark = wr_total;
    do_start(16'd1);
    send_word(32'h0000000C, 32'h0, 1'b0, 1'b1);
    chk("reload_nwr", wr_total - wr_mark, 1);

    // Two-word load with random byte_valid gaps.
    wr_mark = wr_total;
    do_start(16'd2);
    send_word(32'h12345678, 32'h0, 1'b1, 1'b0);
    send_word(32'h9ABCDEF0, 32'h4, 1'b1, 1'b1);
    chk("gap_nwr", wr_total - wr_mark, 2);

    // Bad length in DONE keeps the program running.
    bad_start(16'd0, 1'b1);
    bad_start(16'd257, 1'b1);

    // Start while busy is ignored.
    wr_mark = wr_total;
    do_start(16'd1);
    byte_valid = 1'b1; byte_in = 8'h11; tick;
    byte_valid = 1'b0; start = 1'b1; word_count = 16'd5; tick;
    start = 1'b0;
    chk("busy_start_err", err_length, 0);
    chk("busy_start_busy", busy, 1);
    byte_valid = 1'b1; byte_in = 8'h22; tick;
    byte_valid = 1'b1; byte_in = 8'h33; tick;
    byte_valid = 1'b1; byte_in = 8'h44; tick;
    byte_valid = 1'b0;
    chk("busy_wr_we", wen, 1);
    chk("busy_wr_data", data, 32'h11223344);
    chk("busy_wr_addr", addr, 32'h0);
    tick;
    chk("busy_done", done, 1);
    chk("busy_nwr", wr_total - wr_mark, 1);

    // Reset after two bytes of a one-word load.
    wr_mark = wr_total;
    do_start(16'd1);
    byte_valid = 1'b1; byte_in = 8'h55; tick;
    byte_valid = 1'b1; byte_in = 8'h66; tick;
    byte_valid = 1'b0;
    reset = 1'b1; tick;
    reset = 1'b0;
    chk("mid_rst_we", wen, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cpu_rst", cpu_reset, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdy", byte_ready, 0);
    chk("mid_rst_addr", addr, 32'h0);
    chk("mid_rst_data", data, 32'h0);
    repeat (3) tick;
    chk("mid_rst_nwr", wr_total - wr_mark, 0);
    do_start(16'd1);
    send_word(32'hAABBCCDD, 32'h0, 1'b0, 1'b1);
    chk("mid_rst_fresh_nwr", wr_total - wr_mark, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
